pc_sequencer: RTL

//   Parametrised fetch-stage program counter for the pipelined MIPS core.

---
 rtl/pc_pkg.sv | 6 +
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_ras.sv | 52 +++++
 rtl/pc_sequencer.sv | 71 +++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and the next-PC select encoding for the fetch-stage sequencer.
package pc_pkg;
   localparam int DEF_ADDR_W = 32;
   localparam int PC_INC = 4;
   typedef enum logic [2:0] {SEL_SEQ, SEL_JMP, SEL_RET, SEL_BR, SEL_HOLD} pc_sel_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: redirect requests into the sequencer and PC/RAS status out of it.
interface pc_sequencer_if import pc_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W) ();
   logic              stall_i;
   logic              branch_taken_i;
   logic [ADDR_W-1:0] branch_target_i;
   logic              jump_i;
   logic [ADDR_W-1:0] jump_target_i;
   logic              call_i;
   logic [ADDR_W-1:0] ret_addr_i;
   logic              ret_i;
   logic [ADDR_W-1:0] ret_target_i;
   logic [ADDR_W-1:0] pc_o;
   logic [ADDR_W-1:0] pc_plus4_o;
   logic              ras_empty_o;
   logic              ras_full_o;
   logic              misalign_o;
   logic [ADDR_W-1:0] epc_o;
   modport master (
      output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
             call_i, ret_addr_i, ret_i, ret_target_i,
      input  pc_o, pc_plus4_o, ras_empty_o, ras_full_o, misalign_o, epc_o
   );
   modport slave (
      input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
             call_i, ret_addr_i, ret_i, ret_target_i,
      output pc_o, pc_plus4_o, ras_empty_o, ras_full_o, misalign_o, epc_o
   );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras import pc_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] wdata,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);
   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];
   logic [PW-1:0]     ptr_q, ptr_d, top_idx;
   logic [PW:0]       cnt_q, cnt_d;
   assign top_idx = ptr_q - PW'(1);
   assign top     = mem_q[top_idx];
   assign empty   = cnt_q == '0;
   assign full    = cnt_q == CNT_MAX;
   // Simultaneous push+pop on a non-empty stack rewrites the top in place.
   always_comb begin
      mem_d = mem_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push && pop && !empty) begin
         mem_d[top_idx] = wdata;
      end else if (push) begin
         mem_d[ptr_q] = wdata;
         ptr_d = ptr_q + PW'(1);
         cnt_d = full ? cnt_q : cnt_q + 1'b1;
      end else if (pop && !empty) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - 1'b1;
      end
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mem_q <= '{default: '0};
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with branch/stall/return/jump priority and a RAS.
// Define PC_MISALIGN_TRAP_EN to trap misaligned targets to TRAP_VEC instead of masking them.
module pc_sequencer import pc_pkg::*; #(
   parameter int              ADDR_W    = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int              RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'('h80)
) (
   input logic clk_i,
   input logic rst_i,
   pc_sequencer_if.slave bus
);
   pc_sel_e           sel;
   logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4, tgt, ras_top;
   logic              ras_empty, ras_full, push, pop, redirect;
   assign sel = bus.branch_taken_i ? SEL_BR :
                bus.stall_i        ? SEL_HOLD :
                bus.ret_i          ? SEL_RET :
                bus.jump_i         ? SEL_JMP : SEL_SEQ;
   assign push     = bus.call_i && !bus.branch_taken_i && !bus.stall_i;
   assign pop      = bus.ret_i && !bus.branch_taken_i && !bus.stall_i;
   assign redirect = sel == SEL_BR || sel == SEL_RET || sel == SEL_JMP;
   assign pc_plus4 = pc_q + ADDR_W'(PC_INC);
   assign tgt = sel == SEL_BR  ? bus.branch_target_i :
                sel == SEL_RET ? (ras_empty ? bus.ret_target_i : ras_top) : bus.jump_target_i;
   pc_ras #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push),
      .pop   (pop),
      .wdata (bus.ret_addr_i),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full)
   );
`ifdef PC_MISALIGN_TRAP_EN
   logic              trap, misalign_q, misalign_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   always_comb begin
      trap       = redirect && tgt[1:0] != 2'b00;
      pc_d       = trap ? TRAP_VEC : redirect ? tgt : sel == SEL_HOLD ? pc_q : pc_plus4;
      misalign_d = trap;
      epc_d      = trap ? tgt : epc_q;
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         misalign_q <= 1'b0;
         epc_q      <= '0;
      end else begin
         misalign_q <= misalign_d;
         epc_q      <= epc_d;
      end
   end
   assign bus.misalign_o = misalign_q;
   assign bus.epc_o      = epc_q;
`else
   always_comb begin
      pc_d = redirect ? {tgt[ADDR_W-1:2], 2'b00} : sel == SEL_HOLD ? pc_q : pc_plus4;
   end
   assign bus.misalign_o = 1'b0;
   assign bus.epc_o      = '0;
`endif
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end
   assign bus.pc_o        = pc_q;
   assign bus.pc_plus4_o  = pc_plus4;
   assign bus.ras_empty_o = ras_empty;
   assign bus.ras_full_o  = ras_full;
endmodule
